// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares one synchronous data-memory port between the CPU MEM stage
//            and a debug/loader requester; aligns lanes, routes read data and
//            raises the CPU stall. Optional build macro: DMEM_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_i,
    input  logic [3:0]        cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic              cpu_stall_o,
    output logic              cpu_rvalid_o,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_misalign_o,
    input  logic              dbg_req_i,
    input  logic [3:0]        dbg_we_i,
    input  logic [31:0]       dbg_addr_i,
    input  logic [31:0]       dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [31:0]       dbg_rdata_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DBG  = 2'd2
    } owner_t;

    owner_t              owner_q, owner_d;
    logic                rd_q, rd_d;
    logic [31:0]         cpu_rdata_q;
    logic [31:0]         dbg_rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    logic [1:0]          w_off;
    logic [3:0]          w_cpu_lanes;
    logic                w_cpu_illegal;
    logic                w_cpu_win;
    logic                w_dbg_win;

    // Size mask is shifted into the byte lanes addressed by the low address bits
    always_comb begin
        w_off         = cpu_addr_i[1:0];
        w_cpu_lanes   = 4'b0000;
        w_cpu_illegal = 1'b0;
        case (cpu_we_i)
            4'b0001: w_cpu_lanes = 4'b0001 << w_off;
            4'b0011: begin
                w_cpu_lanes   = 4'b0011 << w_off;
                w_cpu_illegal = w_off[0];
            end
            4'b1111: begin
                w_cpu_lanes   = 4'b1111;
                w_cpu_illegal = |w_off;
            end
            default: w_cpu_lanes = 4'b0000;
        endcase
    end

`ifdef DMEM_ARB_RR_EN
    // Reset value makes debug the first winner of a simultaneous request
    logic last_dbg_q;

    assign w_dbg_win = dbg_req_i & (~cpu_req_i | ~last_dbg_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dbg_q <= 1'b0;
        end else if (w_cpu_win || w_dbg_win) begin
            last_dbg_q <= w_dbg_win;
        end
    end
`else
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_q;

    assign w_dbg_win = dbg_req_i & (~cpu_req_i | (wait_cnt_q >= C_MAX_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (!dbg_req_i || w_dbg_win) begin
            wait_cnt_q <= '0;
        end else if (wait_cnt_q < C_MAX_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`endif

    assign w_cpu_win = cpu_req_i & ~w_dbg_win;

    assign cpu_stall_o    = cpu_req_i & ~w_cpu_win;
    assign dbg_gnt_o      = w_dbg_win;
    assign cpu_misalign_o = cpu_req_i & w_cpu_illegal;

    // Port mux; the address register keeps the RAM address stable while idle
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_o    = 4'b0000;
        mem_wdata_o = 32'h0;
        owner_d     = ST_IDLE;
        rd_d        = 1'b0;
        if (w_cpu_win) begin
            mem_addr_d  = cpu_addr_i[ADDR_W+1:2];
            mem_we_o    = w_cpu_illegal ? 4'b0000 : w_cpu_lanes;
            mem_wdata_o = cpu_wdata_i;
            owner_d     = ST_CPU;
            rd_d        = ~|w_cpu_lanes;
        end else if (w_dbg_win) begin
            mem_addr_d  = dbg_addr_i[ADDR_W+1:2];
            mem_we_o    = dbg_we_i;
            mem_wdata_o = dbg_wdata_i;
            owner_d     = ST_DBG;
            rd_d        = ~|dbg_we_i;
        end
    end

    assign mem_addr_o = mem_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= ST_IDLE;
            rd_q        <= 1'b0;
            mem_addr_q  <= '0;
            cpu_rdata_q <= 32'h0;
            dbg_rdata_q <= 32'h0;
        end else begin
            owner_q    <= owner_d;
            rd_q       <= rd_d;
            mem_addr_q <= mem_addr_d;
            if (cpu_rvalid_o) begin
                cpu_rdata_q <= mem_rdata_i;
            end
            if (dbg_rvalid_o) begin
                dbg_rdata_q <= mem_rdata_i;
            end
        end
    end

    // RAM data arrives during the return cycle; outside it the last value is held
    assign cpu_rvalid_o = (owner_q == ST_CPU) & rd_q;
    assign dbg_rvalid_o = (owner_q == ST_DBG) & rd_q;
    assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : cpu_rdata_q;
    assign dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : dbg_rdata_q;

    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{cpu_addr_i[31:ADDR_W+2], dbg_addr_i[31:ADDR_W+2],
                                  dbg_addr_i[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Purpose  : Self-checking bench for dmem_port_arbiter with a BRAM model and
//            read-return scoreboard queues.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_port_arbiter;

    localparam int ADDR_W   = 12;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_req;
    logic [3:0]        cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;
    logic              cpu_misalign;
    logic              dbg_req;
    logic [3:0]        dbg_we;
    logic [31:0]       dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [31:0]       dbg_rdata;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] cpu_exp_q[$];
    logic [31:0] dbg_exp_q[$];
    logic [31:0] ram [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_i      (cpu_req),
        .cpu_we_i       (cpu_we),
        .cpu_addr_i     (cpu_addr),
        .cpu_wdata_i    (cpu_wdata),
        .cpu_stall_o    (cpu_stall),
        .cpu_rvalid_o   (cpu_rvalid),
        .cpu_rdata_o    (cpu_rdata),
        .cpu_misalign_o (cpu_misalign),
        .dbg_req_i      (dbg_req),
        .dbg_we_i       (dbg_we),
        .dbg_addr_i     (dbg_addr),
        .dbg_wdata_i    (dbg_wdata),
        .dbg_gnt_o      (dbg_gnt),
        .dbg_rvalid_o   (dbg_rvalid),
        .dbg_rdata_o    (dbg_rdata),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    // Synchronous BRAM, one-cycle read latency, read-before-write
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Read-return scoreboard
    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (cpu_exp_q.size() == 0) check_val("cpu_spurious_rvalid", 32'd1, 32'd0);
            else check_val("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
        end
        if (dbg_rvalid) begin
            if (dbg_exp_q.size() == 0) check_val("dbg_spurious_rvalid", 32'd1, 32'd0);
            else check_val("dbg_rdata", dbg_rdata, dbg_exp_q.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wd);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic set_dbg(input logic req, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wd);
        dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    endtask

    function automatic logic exp_dbg_win(input int k);
`ifdef DMEM_ARB_RR_EN
        return (k % 2) == 0;
`else
        return (k == MAX_WAIT) || (k == 2 * MAX_WAIT + 1);
`endif
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_cpu(0, 4'b0000, 32'h0, 32'h0);
        set_dbg(0, 4'b0000, 32'h0, 32'h0);
        #2;
        check_val("rst_cpu_rvalid", cpu_rvalid, 0);
        check_val("rst_dbg_rvalid", dbg_rvalid, 0);
        check_val("rst_cpu_rdata", cpu_rdata, 0);
        check_val("rst_dbg_rdata", dbg_rdata, 0);
        check_val("rst_mem_we", mem_we, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_stall", cpu_stall, 0);
        check_val("rst_gnt", dbg_gnt, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Preload through the debug write path
        set_dbg(1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF);
        #2;
        check_val("dbgw_gnt", dbg_gnt, 1);
        check_val("dbgw_we", mem_we, 4'b1111);
        check_val("dbgw_addr", mem_addr, 4);
        next_cycle();
        set_dbg(1, 4'b1111, 32'h0000_0020, 32'h1234_5678);
        next_cycle();
        set_dbg(0, 4'b0000, 32'h0, 32'h0);

        // CPU load
        set_cpu(1, 4'b0000, 32'h0000_0010, 32'h0);
        cpu_exp_q.push_back(32'hDEAD_BEEF);
        #2;
        check_val("ld_addr", mem_addr, 4);
        check_val("ld_we", mem_we, 0);
        check_val("ld_stall", cpu_stall, 0);
        check_val("ld_misalign", cpu_misalign, 0);
        next_cycle();

        // Byte store to lane 3
        set_cpu(1, 4'b0001, 32'h0000_0013, 32'hABAB_ABAB);
        #2;
        check_val("sb_we", mem_we, 4'b1000);
        check_val("sb_addr", mem_addr, 4);
        check_val("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        check_val("sb_misalign", cpu_misalign, 0);
        next_cycle();

        // Half store at offset 3 is illegal
        set_cpu(1, 4'b0011, 32'h0000_0013, 32'h5555_5555);
        #2;
        check_val("sh3_we", mem_we, 0);
        check_val("sh3_misalign", cpu_misalign, 1);
        check_val("sh3_stall", cpu_stall, 0);
        next_cycle();

        // Half store at offset 2
        set_cpu(1, 4'b0011, 32'h0000_0012, 32'hCDCD_CDCD);
        #2;
        check_val("sh2_we", mem_we, 4'b1100);
        check_val("sh2_misalign", cpu_misalign, 0);
        next_cycle();

        // Word store at offset 1 is illegal
        set_cpu(1, 4'b1111, 32'h0000_0011, 32'h7777_7777);
        #2;
        check_val("sw1_we", mem_we, 0);
        check_val("sw1_misalign", cpu_misalign, 1);
        next_cycle();

        // Aligned word store to word 12
        set_cpu(1, 4'b1111, 32'h0000_0030, 32'h0BAD_F00D);
        #2;
        check_val("sw0_we", mem_we, 4'b1111);
        check_val("sw0_addr", mem_addr, 12);
        next_cycle();

        // Load at an odd offset is never misaligned
        set_cpu(1, 4'b0000, 32'h0000_0013, 32'h0);
        cpu_exp_q.push_back(32'hCDCD_BEEF);
        #2;
        check_val("ld3_misalign", cpu_misalign, 0);
        next_cycle();

        // Unsupported mask behaves as a load
        set_cpu(1, 4'b0101, 32'h0000_0030, 32'hFFFF_FFFF);
        cpu_exp_q.push_back(32'h0BAD_F00D);
        #2;
        check_val("bad_mask_we", mem_we, 0);
        check_val("bad_mask_misalign", cpu_misalign, 0);
        next_cycle();

        // Back-to-back CPU then debug reads
        set_cpu(1, 4'b0000, 32'h0000_0010, 32'h0);
        cpu_exp_q.push_back(32'hCDCD_BEEF);
        next_cycle();
        set_cpu(0, 4'b0000, 32'h0, 32'h0);
        set_dbg(1, 4'b0000, 32'h0000_0020, 32'h0);
        dbg_exp_q.push_back(32'h1234_5678);
        #2;
        check_val("b2b_gnt", dbg_gnt, 1);
        check_val("b2b_addr", mem_addr, 8);
        next_cycle();
        set_dbg(0, 4'b0000, 32'h0, 32'h0);
        #2;
        check_val("b2b_dbg_rvalid", dbg_rvalid, 1);
        check_val("b2b_cpu_rvalid", cpu_rvalid, 0);
        check_val("b2b_cpu_hold", cpu_rdata, 32'hCDCD_BEEF);
        check_val("idle_addr_hold", mem_addr, 8);
        check_val("idle_we", mem_we, 0);
        check_val("idle_gnt", dbg_gnt, 0);
        next_cycle();

        // Reset asserted while a CPU read is in flight
        set_cpu(1, 4'b0000, 32'h0000_0010, 32'h0);
        #2;
        check_val("rr_grant_stall", cpu_stall, 0);
        rst_n = 1'b0;
        #1;
        check_val("async_cpu_rdata", cpu_rdata, 0);
        check_val("async_dbg_rdata", dbg_rdata, 0);
        check_val("async_cpu_rvalid", cpu_rvalid, 0);
        next_cycle();
        check_val("rst_inflight_rvalid", cpu_rvalid, 0);
        set_cpu(0, 4'b0000, 32'h0, 32'h0);
        rst_n = 1'b1;
        next_cycle();

        // Contention with both requesting every cycle
        for (int k = 0; k < 2 * MAX_WAIT + 2; k++) begin
            logic dw;
            dw = exp_dbg_win(k);
            set_cpu(1, 4'b0000, 32'h0000_0010, 32'h0);
            set_dbg(1, 4'b0000, 32'h0000_0020, 32'h0);
            if (dw) dbg_exp_q.push_back(32'hCDCD_BEEF == 0 ? 0 : 32'h1234_5678);
            else    cpu_exp_q.push_back(32'hCDCD_BEEF);
            #2;
            check_val($sformatf("cont_gnt_%0d", k), dbg_gnt, dw);
            check_val($sformatf("cont_stall_%0d", k), cpu_stall, dw);
            check_val($sformatf("cont_addr_%0d", k), mem_addr, dw ? 8 : 4);
            next_cycle();
        end
        set_cpu(0, 4'b0000, 32'h0, 32'h0);
        set_dbg(0, 4'b0000, 32'h0, 32'h0);
        next_cycle();
        next_cycle();

        check_val("cpu_queue_drained", cpu_exp_q.size(), 0);
        check_val("dbg_queue_drained", dbg_exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the pipeline's MEM-stage load/store requester and the debug/loader requester.
- The memory is a synchronous BRAM with 1-cycle read latency.
- Per cycle, the block grants the port to one requester, aligns byte-lane enables, routes read data back to the owner one cycle later, and produces the CPU stall that freezes the MEM/WB segment registers.
- Debug access is starvation-protected by a wait counter.

Parameters:
- ADDR_W, 12: word-address width driven to the RAM (byte address bits [ADDR_W+1:2]).
- MAX_WAIT, 4: cycles dbg_req may be refused before it pre-empts the CPU; 0 = debug always wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request, held stable while cpu_stall=1.
- cpu_we  in  4  CPU write size mask: 0000 load, 0001 byte, 0011 half, 1111 word.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data, already lane-replicated.
- cpu_stall  out  1  CPU request not serviced this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  32  CPU read data.
- cpu_misalign  out  1  current CPU request is misaligned; write suppressed.
- dbg_req  in  1  debug request, held until dbg_gnt.
- dbg_we  in  4  debug lane enables, used unshifted.
- dbg_addr  in  32  debug byte address.
- dbg_wdata  in  32  debug write data.
- dbg_gnt  out  1  debug request accepted this cycle (1-cycle pulse).
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  32  debug read data.
- mem_we  out  4  RAM byte write enables.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid 1 cycle after address.

Behaviour:
- Reset (async assert, sync deassert): owner=IDLE, wait_cnt=0, cpu_rvalid=0, dbg_rvalid=0, cpu_rdata=0, dbg_rdata=0. Combinational outputs follow the grant rules with idle state, i.e. 0 when no request.
- Grant (combinational, per cycle):
  - dbg_win = dbg_req & (~cpu_req | wait_cnt >= MAX_WAIT).
  - cpu_win = cpu_req & ~dbg_win.
  - At most one winner per cycle.
- cpu_stall = cpu_req & ~cpu_win. dbg_gnt = dbg_win.
- mem_addr/mem_wdata come from the winner. When there is no winner, mem_we=0 and mem_addr holds its last value.
- CPU lane alignment (off = cpu_addr[1:0]):
  - 0001: mask << off.
  - 0011: mask << off, legal only for off in {0,2}.
  - 1111: legal only for off=0.
  - Any other mask: treated as 0000.
  - Illegal offset: cpu_misalign=1, mem_we=0, request still completes (no stall added).
  - cpu_misalign is 0 for loads.
- Owner state machine (registered), states IDLE, CPU, DBG. Next state = CPU if cpu_win, DBG if dbg_win, else IDLE.
- Read return: in the cycle after a grant with zero write mask, the owner's rvalid=1 and its rdata = mem_rdata. Writes never raise rvalid. Latency is exactly 1 cycle, back-to-back grants supported.
- rdata hold: each rdata output holds its last returned value while its rvalid=0. The CPU pipeline's stall/clear mux relies on this.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when dbg_req & ~dbg_gnt.
  - Clears to 0 on dbg_gnt or when dbg_req=0.
- Simultaneous requests: the CPU wins until starvation, then debug wins exactly one cycle, the counter clears, and the CPU resumes.
- Reset mid-read: the in-flight rvalid is discarded and never asserted.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: wait_cnt and MAX_WAIT are unused. A 1-bit last-winner register makes simultaneous requests alternate strictly, with debug first after reset.
- Undefined: CPU priority with starvation counter as above.

Test Plan:
- CPU load only: cpu_req=1, cpu_we=0000, addr=0x0000_0010, RAM word 4 = 0xDEADBEEF -> mem_addr=4, mem_we=0000, no stall; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
- CPU store byte: cpu_we=0001, addr=0x0000_0013 -> mem_we=1000, mem_addr=4. Then half at offset 3 -> mem_we=0000, cpu_misalign=1.
- Contention (MAX_WAIT=4): cpu_req held 1, dbg_req=1 from cycle 0 -> dbg_gnt at cycle 4 only, cpu_stall=1 at cycle 4 only, wait_cnt back to 0 at cycle 5.
- Back-to-back: CPU read, then debug read of word 8 = 0x12345678 in consecutive cycles -> cpu_rvalid then dbg_rvalid on successive cycles, correct data, no cross-routing; cpu_rdata holds its value while dbg_rvalid=1.
- Async reset: assert rst_n=0 in the cycle after a CPU read grant -> cpu_rvalid stays 0, all registered outputs 0 immediately, without waiting for clk.
- With DMEM_ARB_RR_EN: both requesting continuously -> grants alternate D, C, D, C starting with debug after reset.
